// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative radix-2 HI/LO multiply/divide sequencer for the Harvard MIPS core.
// Optional macro MULDIV_EARLY_EXIT_EN: multiply stops once the remaining multiplier bits are zero.
module mips_cpu_muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        mf_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [63:0] acc_reg, acc_next;
  logic [63:0] mcand_reg, mcand_next;
  logic [31:0] mplr_reg, mplr_next;
  logic        sign_reg, sign_next;
  logic        rsign_reg, rsign_next;
  logic        is_div_reg, is_div_next;
  logic        dz_reg, dz_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;

  logic        is_signed;
  logic [31:0] rs_mag, rt_mag;
  logic [63:0] mul_sum;
  logic [32:0] div_diff;
  logic        last_iter;
  logic        mul_exit;

  // MULT and DIV are the even opcodes; odd ones are the unsigned variants.
  assign is_signed = ~op[0];
  assign rs_mag    = (is_signed && rs[31]) ? -rs : rs;
  assign rt_mag    = (is_signed && rt[31]) ? -rt : rt;
  assign mul_sum   = acc_reg + (mplr_reg[0] ? mcand_reg : 64'd0);
  // Remainder shifted left by one is 33 bits wide before the trial subtract.
  assign div_diff  = acc_reg[63:31] - {1'b0, mcand_reg[31:0]};
  assign last_iter = (cnt_reg == 6'(ITER - 1));

`ifdef MULDIV_EARLY_EXIT_EN
  assign mul_exit = last_iter || (mplr_reg[31:1] == 31'd0);
`else
  assign mul_exit = last_iter;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplr_next   = mplr_reg;
    sign_next   = sign_reg;
    rsign_next  = rsign_reg;
    is_div_next = is_div_reg;
    dz_next     = dz_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              acc_next    = 64'd0;
              mcand_next  = {32'd0, rs_mag};
              mplr_next   = rt_mag;
              sign_next   = is_signed & (rs[31] ^ rt[31]);
              is_div_next = 1'b0;
              dz_next     = 1'b0;
              cnt_next    = 6'd0;
              state_next  = MUL;
            end
            3'd2, 3'd3: begin
              is_div_next = 1'b1;
              sign_next   = is_signed & (rs[31] ^ rt[31]);
              rsign_next  = is_signed & rs[31];
              mplr_next   = rs;  // raw dividend, returned in HI on divide by zero
              acc_next    = {32'd0, rs_mag};
              mcand_next  = {32'd0, rt_mag};
              cnt_next    = 6'd0;
              if (rt == 32'd0) begin
                dz_next    = 1'b1;
                state_next = FIXUP;
              end else begin
                dz_next    = 1'b0;
                state_next = DIV;
              end
            end
            3'd4:    hi_next = rs;
            3'd5:    lo_next = rs;
            default: ;
          endcase
        end
      end

      MUL: begin
        acc_next   = mul_sum;
        mcand_next = {mcand_reg[62:0], 1'b0};
        mplr_next  = {1'b0, mplr_reg[31:1]};
        cnt_next   = cnt_reg + 6'd1;
        if (mul_exit)
          state_next = FIXUP;
      end

      DIV: begin
        if (!div_diff[32])
          acc_next = {div_diff[31:0], acc_reg[30:0], 1'b1};
        else
          acc_next = {acc_reg[62:0], 1'b0};
        cnt_next = cnt_reg + 6'd1;
        if (last_iter)
          state_next = FIXUP;
      end

      FIXUP: begin
        if (dz_reg) begin
          hi_next = mplr_reg;
          lo_next = 32'hFFFF_FFFF;
        end else if (is_div_reg) begin
          lo_next = sign_reg  ? -acc_reg[31:0]  : acc_reg[31:0];
          hi_next = rsign_reg ? -acc_reg[63:32] : acc_reg[63:32];
        end else begin
          {hi_next, lo_next} = sign_reg ? -acc_reg : acc_reg;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 6'd0;
      acc_reg    <= 64'd0;
      mcand_reg  <= 64'd0;
      mplr_reg   <= 32'd0;
      sign_reg   <= 1'b0;
      rsign_reg  <= 1'b0;
      is_div_reg <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      done_reg   <= 1'b0;
    end else if (clk_enable) begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplr_reg   <= mplr_next;
      sign_reg   <= sign_next;
      rsign_reg  <= rsign_next;
      is_div_reg <= is_div_next;
      dz_reg     <= dz_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

  assign busy  = (state_reg != IDLE);
  assign stall = busy && (start || mf_req);
  assign done  = done_reg;
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Scoreboard bench for mips_cpu_muldiv_seq: stimulus queues expected HI/LO and latency,
// a monitor pops and compares on every done pulse.
module tb_mips_cpu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        mf_req;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  mips_cpu_muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs(rs), .rt(rt), .mf_req(mf_req), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Multiply latency in cycles from the start edge, given |rt|.
  function automatic int mul_lat(input logic [31:0] m);
`ifdef MULDIV_EARLY_EXIT_EN
    int k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    return k + 2;
`else
    return (m == 32'd0) ? 33 : 33;
`endif
  endfunction

  // Monitor: compare each done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_width", {31'd0, done}, 32'd0);
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("latency", cyc - e.issue, e.lat);
        $display("[TB] result hi=0x%08h lo=0x%08h latency=%0d", hi, lo, cyc - e.issue);
      end
    end
    prev_done = done;
  end

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  // Called and returns at a negedge; the request is accepted on the next posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    wait_not_busy();
    op = o; rs = a; rt = b; start = 1'b1;
    if (o < 3'd4) begin
      e.hi = eh; e.lo = el; e.lat = lat; e.issue = cyc + 1;
      sb.push_back(e);
    end
    $display("[TB] issue op=%0d rs=0x%08h rt=0x%08h", o, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] hi_snap, lo_snap;
    logic        stall_bad;
    int          n;
    exp_t        e;

    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd0;
    rs = 32'd0; rt = 32'd0; mf_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
          mul_lat(32'hFFFF_FFFF));
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, mul_lat(32'd7));
    wait_idle();
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 32'd0, 32'd0, 0);
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, 32'hFFFF_FFEB);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    issue(OP_MTLO, 32'h1357_9BDF, 32'd0, 32'd0, 32'd0, 0);
    check("mtlo_lo", lo, 32'h1357_9BDF);

    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    issue(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33);
    issue(OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    issue(OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2, 33);
    issue(OP_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 33);
    issue(OP_MULT, 32'h1234_5678, 32'd0, 32'd0, 32'd0, mul_lat(32'd0));
    wait_idle();

    // Held request and MFxx while busy must stall; the held start is taken once busy drops.
    issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, mul_lat(32'h0001_0000));
    repeat (3) @(negedge clk);
    mf_req = 1'b1; op = OP_MULTU; rs = 32'd2; rt = 32'd3; start = 1'b1;
    #1 check("stall_busy", {31'd0, stall}, 32'd1);
    stall_bad = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      if (!stall) stall_bad = 1'b1;
    end
    check("stall_held", {31'd0, stall_bad}, 32'd0);
    check("stall_free", {31'd0, stall}, 32'd0);
    e.hi = 32'd0; e.lo = 32'd6; e.lat = mul_lat(32'd3); e.issue = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; mf_req = 1'b0;
    check("second_accept_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset in the middle of a divide discards it; the monitor flags any done.
    op = OP_DIV; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);

    // Freeze for 5 cycles mid-multiply.
    issue(OP_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, mul_lat(32'd2) + 5);
    @(negedge clk);
    hi_snap = hi; lo_snap = lo;
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    check("freeze_hi", hi, hi_snap);
    check("freeze_lo", lo, lo_snap);
    check("freeze_busy", {31'd0, busy}, 32'd1);
    clk_enable = 1'b1;
    wait_idle();
    issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, mul_lat(32'd7));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
